// File: rtl/dmem_block_responder_if.sv
// Cache <-> data memory block bus.
// The cache is the master. It issues read/write requests and holds them until
// it sees busywait low. The memory is the slave. It returns a block and busywait.
interface dmem_block_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    // Cache side: drives requests, observes data and busywait.
    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_writedata,
        input  mem_readdata,
        input  mem_busywait
    );

    // Memory side: observes requests, drives data and busywait.
    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_writedata,
        output mem_readdata,
        output mem_busywait
    );
endinterface

// File: rtl/dmem_block_responder.sv
// Block-organised data memory behind the data cache.
// It serves 32-bit block refills (reads) and dirty write-backs (writes) with a
// fixed latency. A request is latched in IDLE and completes LATENCY edges later.
// One ACK cycle follows completion. During ACK the cache drops its still-held
// request, so the same request is not accepted a second time.
// All outputs come straight from registers.
module dmem_block_responder #(
    parameter int LATENCY    = 5,   // edges from acceptance to completion, 1..15
    parameter int NUM_BLOCKS = 64   // 32-bit blocks, addressed by 6 bits
) (
    input  logic                         clock,
    input  logic                         reset,      // asynchronous, active low
    dmem_block_responder_if.slave        mem,
    output logic                         proto_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_counter;
    logic        r_busywait;
    logic [31:0] r_readdata;
    logic        r_proto_err;
    logic [5:0]  r_addr;
    logic [31:0] r_data;
    logic        r_op_write;

    logic [31:0] r_array [NUM_BLOCKS];

    logic        w_request;
    logic        w_complete;
    logic        w_array_we;

    assign w_request  = mem.mem_read | mem.mem_write;
    assign w_complete = (r_state == S_ACCESS) && (r_counter == 4'd0);
    assign w_array_we = w_complete && r_op_write;

    // Control FSM: accept in IDLE, count down in ACCESS, one cycle of ACK.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values and the block order cannot matter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_counter   <= 4'd0;
            r_busywait  <= 1'b0;
            r_readdata  <= 32'd0;
            r_proto_err <= 1'b0;
            r_addr      <= 6'd0;
            r_data      <= 32'd0;
            r_op_write  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_request) begin
                        r_addr     <= mem.mem_address;
                        r_data     <= mem.mem_writedata;
                        r_op_write <= mem.mem_write;
                        r_counter  <= CNT_LOAD;
                        r_busywait <= 1'b1;
                        r_state    <= S_ACCESS;
                        if (mem.mem_read && mem.mem_write) begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_counter != 4'd0) begin
                        r_counter <= r_counter - 4'd1;
                    end else begin
                        if (!r_op_write) begin
                            r_readdata <= r_array[r_addr];
                        end
                        r_busywait <= 1'b0;
                        r_state    <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage: written only at a write completion edge.
    // NOTE: the array has no reset. It keeps its contents across reset and
    // maps onto plain RAM. Reset still aborts a pending write, because reset
    // forces the FSM out of ACCESS, and that drops w_array_we.
    always_ff @(posedge clock) begin
        if (w_array_we) begin
            r_array[r_addr] <= r_data;
        end
    end

    assign mem.mem_readdata = r_readdata;
    assign mem.mem_busywait = r_busywait;
    assign proto_err        = r_proto_err;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Directed bench for dmem_block_responder.
// Covers write/read, back-to-back write-back then refill, a request held
// through ACK, simultaneous read+write, and reset during an access.
module tb_dmem_block_responder;

    localparam int LATENCY = 5;

    logic clock;
    logic reset;
    logic proto_err;
    int   n_tests;
    int   n_fail;
    int   cyc;

    dmem_block_responder_if bus ();

    dmem_block_responder #(
        .LATENCY    (LATENCY),
        .NUM_BLOCKS (64)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mem       (bus),
        .proto_err (proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running edge counter, used to measure acceptance gaps.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cache transaction. It drives the request at a negedge and waits for
    // acceptance. It measures busywait and returns the acceptance and
    // completion cycles. With hold set, the request stays up through the ACK edge.
    task automatic op(input string tag, input logic rd, input logic wr,
                      input logic [5:0] addr, input logic [31:0] data,
                      input bit hold, output int acc_cyc, output int comp_cyc);
        int  busy_cnt;
        bit  seen;
        @(negedge clock);
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.mem_address   = addr;
        bus.mem_writedata = data;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (bus.mem_busywait) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_accept"}, 32'(seen), 32'd1);
        acc_cyc  = cyc;
        busy_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (!bus.mem_busywait) break;
            busy_cnt++;
        end
        comp_cyc = cyc;
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(LATENCY));
        if (hold) begin
            @(posedge clock); #1;
            check({tag, "_ack_edge_busy"}, 32'(bus.mem_busywait), 32'd0);
            @(negedge clock);
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            @(posedge clock); #1;
            check({tag, "_no_reaccept"}, 32'(bus.mem_busywait), 32'd0);
        end else begin
            @(negedge clock);
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
        end
    endtask

    int a0, c0, a1, c1;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = 6'd0;
        bus.mem_writedata = 32'd0;

        // Reset for 3 cycles.
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_busywait", 32'(bus.mem_busywait), 32'd0);
        check("rst_readdata", bus.mem_readdata, 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);

        // Write then read back the same address.
        op("wr2a", 1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, 0, a0, c0);
        check("wr2a_rdata_unchanged", bus.mem_readdata, 32'd0);
        op("rd2a", 1'b1, 1'b0, 6'h2A, 32'h0, 0, a0, c0);
        check("rd2a_data", bus.mem_readdata, 32'hDEADBEEF);

        // Prepare 0x25. Then do a write-back followed by a refill.
        op("wr25", 1'b0, 1'b1, 6'h25, 32'hCAFEF00D, 0, a0, c0);
        op("wb05", 1'b0, 1'b1, 6'h05, 32'h11223344, 0, a0, c0);
        check("wb05_rdata_kept", bus.mem_readdata, 32'hDEADBEEF);
        op("rf25", 1'b1, 1'b0, 6'h25, 32'h0, 0, a1, c1);
        check("b2b_gap", 32'(a1 - c0), 32'd2);
        check("rf25_data", bus.mem_readdata, 32'hCAFEF00D);
        op("rd05", 1'b1, 1'b0, 6'h05, 32'h0, 0, a0, c0);
        check("rd05_data", bus.mem_readdata, 32'h11223344);

        // Read request held through ACK: no second access.
        op("hold", 1'b1, 1'b0, 6'h2A, 32'h0, 1, a0, c0);
        check("hold_data", bus.mem_readdata, 32'hDEADBEEF);

        // Simultaneous read+write is taken as a write and flags proto_err.
        op("both", 1'b1, 1'b1, 6'h10, 32'h0000ABCD, 0, a0, c0);
        check("both_proto_err", 32'(proto_err), 32'd1);
        op("rd10", 1'b1, 1'b0, 6'h10, 32'h0, 0, a0, c0);
        check("rd10_data", bus.mem_readdata, 32'h0000ABCD);
        check("proto_err_sticky", 32'(proto_err), 32'd1);

        // Reset during a write: the write is aborted and outputs clear at once.
        op("wr3f", 1'b0, 1'b1, 6'h3F, 32'h12345678, 0, a0, c0);
        @(negedge clock);
        bus.mem_write     = 1'b1;
        bus.mem_address   = 6'h3F;
        bus.mem_writedata = 32'hFFFFFFFF;
        @(posedge clock); #1;
        check("mid_accept", 32'(bus.mem_busywait), 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mid_rst_busywait", 32'(bus.mem_busywait), 32'd0);
        check("mid_rst_readdata", bus.mem_readdata, 32'd0);
        check("mid_rst_proto_err", 32'(proto_err), 32'd0);
        bus.mem_write = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        op("rd3f", 1'b1, 1'b0, 6'h3F, 32'h0, 0, a0, c0);
        check("rd3f_data", bus.mem_readdata, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_block_responder.md
Name: dmem_block_responder

Overview:
- Block-organised data memory that sits on the memory side of the data cache controller.
- Responds to cache-initiated 32-bit block reads (refill) and block writes (dirty write-back).
- Fixed, parameterised access latency; signals progress on a busywait handshake.
- Holds 64 blocks of 4 bytes (256 bytes total), addressed by a 6-bit block address {tag, index}.

Parameters:
- LATENCY, 5, clock edges from request acceptance to completion; legal range 1..15.
- NUM_BLOCKS, 64, number of 32-bit blocks; address width is fixed at 6.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- mem_read  input  1  block read request from the cache; held high until busywait is seen low.
- mem_write  input  1  block write request from the cache; held high until busywait is seen low.
- mem_address  input  6  block address {tag[2:0], index[2:0]}.
- mem_writedata  input  32  block to write; byte 0 is [7:0], byte 3 is [31:24].
- mem_readdata  output  32  returned block; valid from the completion edge until the next completion.
- mem_busywait  output  1  high while an accepted request is in progress.
- proto_err  output  1  sticky flag: read and write were sampled high together in IDLE; cleared only by reset.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, mem_busywait=0, mem_readdata=0, proto_err=0, counter=0.
  - Latched address and data are cleared.
  - The storage array is NOT cleared.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - At a rising edge with mem_read|mem_write high: latch mem_address, latch mem_writedata, latch op (write if mem_write, else read).
  - Same edge: counter<=LATENCY-1, mem_busywait<=1, state<=ACCESS.
  - Both requests high: accepted as a write, proto_err<=1.
  - Neither request high: stay in IDLE, no output changes.
- ACCESS:
  - Each edge with counter!=0: counter<=counter-1.
  - Edge with counter==0 (the completion edge):
    - Read: mem_readdata<=array[latched_addr].
    - Write: array[latched_addr]<=latched_data; mem_readdata unchanged.
    - mem_busywait<=0, state<=ACK.
  - Latency: request sampled at edge E0, completion at edge E0+LATENCY. mem_busywait is high for exactly LATENCY cycles.
  - Input changes during ACCESS are ignored, including a request being withdrawn; the latched operation always completes.
- ACK:
  - Exactly one cycle; requests are ignored; state<=IDLE at the next edge.
  - Purpose: the cache sees busywait low at E0+LATENCY+1 and drops its request there. Without ACK, the request still held high would be re-accepted.
  - A new request is therefore accepted no earlier than E0+LATENCY+2.
- Back-to-back operation (write-back followed by refill): the second request is accepted at the first edge in IDLE at which it is high.
- Reset asserted during ACCESS: the operation is aborted, no array write occurs, and outputs return to their reset values immediately.
- Write followed by read of the same address: the read returns the new data.
- The array is only ever updated at a write completion edge.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> mem_busywait=0, mem_readdata=0, proto_err=0, state IDLE.
- Write/read, LATENCY=5:
  - Write 0xDEADBEEF to address 6'h2A -> busywait high for exactly 5 cycles, then 1 low cycle in ACK.
  - Then read 6'h2A -> mem_readdata=0xDEADBEEF at completion edge E0+5.
- Write-back then refill:
  - Write 0x11223344 to 6'h05, then immediately read 6'h25 (previously written with 0xCAFEF00D) -> second request accepted 2 edges after the first completion.
  - mem_readdata=0xCAFEF00D; address 6'h05 holds 0x11223344.
- Request held through ACK: keep mem_read high 1 cycle past busywait going low -> no second access; busywait stays 0.
- Simultaneous request: mem_read=mem_write=1, address 6'h10, data 0x0000ABCD -> treated as a write, proto_err=1.
  - Proto_err stays 1 through later normal operations until reset.
- Reset mid-op: start a write of 0xFFFFFFFF to 6'h3F (previously 0x12345678) and assert reset 2 cycles in -> busywait falls immediately.
  - After release, a read of 6'h3F returns 0x12345678.
